ssd_num_scanner: RTL and testbench

Parametrised seven-segment display engine for the poker board top level. It takes over all SSD work from the top level: digit scanning, glyph decode, and sequential binary-to-decimal conversion of two balance/bet values. Conversion uses iterative double-dabble, replacing the combinational divide/modulo chains. Display contents are committed atomically once per conversion pass, so digits never show partial updates. It sits between the poker core outputs and the An/Ca..Cg/Dp pins.

---
 rtl/ssd_num_scanner.sv | 201 ++++++++++++++++++++
 tb/tb_ssd_num_scanner.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_num_scanner.sv
// ssd_num_scanner: multiplexed seven-segment engine with a free-running
// double-dabble converter that commits whole display frames atomically.
module ssd_num_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int DWELL_LOG2 = 18,
    parameter int BIN_W      = 8
) (
    input  logic                    board_clk,
    input  logic                    Reset,
    input  logic [1:0]              mode,
    input  logic [4*NUM_DIGITS-1:0] glyphs,
    input  logic [BIN_W-1:0]        val_hi,
    input  logic [BIN_W-1:0]        val_lo,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    conv_done,
    output logic                    ovf_hi,
    output logic                    ovf_lo
);
    localparam int FIELD_DIGITS = NUM_DIGITS / 2;
    // Decimal digits of 2^BIN_W-1 is ceil(BIN_W*log10(2)); 2^n is never a power of ten.
    localparam int DEC_DIGITS   = (BIN_W * 30103) / 100000 + 1;
    localparam int BCD_N        = (DEC_DIGITS + 1 > FIELD_DIGITS) ? DEC_DIGITS + 1 : FIELD_DIGITS;
    localparam int CNT_W        = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int IDX_W        = $clog2(NUM_DIGITS);

    // state     | meaning
    // ST_LOAD   | capture inputs into shadows, clear BCD accumulators
    // ST_SHIFT  | one double-dabble step per cycle, BIN_W cycles
    // ST_COMMIT | publish display registers and overflow flags
    typedef enum logic [1:0] {ST_LOAD, ST_SHIFT, ST_COMMIT} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]        bit_cnt;
    logic [1:0]              mode_s;
    logic [4*NUM_DIGITS-1:0] glyphs_s;
    logic [BIN_W-1:0]        sh_hi, sh_lo;
    logic                    blz_s;
    logic [4*BCD_N-1:0]      bcd_hi, bcd_lo;
    logic [4*NUM_DIGITS-1:0] disp, disp_new, disp_nxt, num_codes;
    logic                    ovf_hi_c, ovf_lo_c;
    logic [DWELL_LOG2-1:0]   dwell_cnt;
    logic [IDX_W-1:0]        idx, idx_nxt;

    function automatic logic [4*BCD_N-1:0] dabble(input logic [4*BCD_N-1:0] bcd,
                                                  input logic bit_in);
        logic [4*BCD_N-1:0] adj;
        adj = bcd;
        for (int k = 0; k < BCD_N; k++) begin
            if (adj[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        return {adj[4*BCD_N-2:0], bit_in};
    endfunction

    function automatic logic [4*FIELD_DIGITS-1:0] field_codes(input logic [4*BCD_N-1:0] bcd,
                                                              input logic blz,
                                                              input logic ovf);
        logic [4*FIELD_DIGITS-1:0] codes;
        logic                      lead;
        codes = '0;
        lead  = blz;
        for (int j = FIELD_DIGITS - 1; j >= 0; j--) begin
            if (ovf)
                codes[4*j +: 4] = 4'hF;
            else if (bcd[4*j +: 4] != 4'd0) begin
                codes[4*j +: 4] = bcd[4*j +: 4];
                lead            = 1'b0;
            end else if (lead && j != 0)
                codes[4*j +: 4] = 4'h0;
            else
                codes[4*j +: 4] = 4'hA;
        end
        return codes;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        unique case (code)
            4'h0: s = 7'b1111111;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0000001;
            4'hB: s = 7'b1000111;
            4'hC: s = 7'b0001100;
            4'hD: s = 7'b1001000;
            4'hE: s = 7'b0001000;
            4'hF: s = 7'b0011000;
        endcase
        return s;
    endfunction

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) state <= ST_LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_LOAD;
        unique case (state)
            ST_LOAD:   state_nxt = ST_SHIFT;
            ST_SHIFT:  state_nxt = (bit_cnt == '0) ? ST_COMMIT : ST_SHIFT;
            ST_COMMIT: state_nxt = ST_LOAD;
            default:   state_nxt = ST_LOAD;
        endcase
    end

    // Overflow lives in the nibbles above the field width.
    always_comb begin
        ovf_hi_c = 1'b0;
        ovf_lo_c = 1'b0;
        for (int k = FIELD_DIGITS; k < BCD_N; k++) begin
            if (bcd_hi[4*k +: 4] != 4'd0) ovf_hi_c = 1'b1;
            if (bcd_lo[4*k +: 4] != 4'd0) ovf_lo_c = 1'b1;
        end
        num_codes = {field_codes(bcd_hi, blz_s, ovf_hi_c), field_codes(bcd_lo, blz_s, ovf_lo_c)};
        disp_new  = glyphs_s;
        if (mode_s == 2'd1)
            disp_new = num_codes;
        else if (mode_s == 2'd2)
            disp_new[4*FIELD_DIGITS-1:0] = num_codes[4*FIELD_DIGITS-1:0];
        disp_nxt = (state == ST_COMMIT) ? disp_new : disp;
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            bit_cnt   <= '0;
            mode_s    <= '0;
            glyphs_s  <= '0;
            sh_hi     <= '0;
            sh_lo     <= '0;
            blz_s     <= 1'b0;
            bcd_hi    <= '0;
            bcd_lo    <= '0;
            disp      <= '0;
            conv_done <= 1'b0;
            ovf_hi    <= 1'b0;
            ovf_lo    <= 1'b0;
        end else begin
            conv_done <= (state == ST_COMMIT);
            unique case (state)
                ST_LOAD: begin
                    bit_cnt  <= CNT_W'(BIN_W - 1);
                    mode_s   <= mode;
                    glyphs_s <= glyphs;
                    sh_hi    <= val_hi;
                    sh_lo    <= val_lo;
                    blz_s    <= blank_lz;
                    bcd_hi   <= '0;
                    bcd_lo   <= '0;
                end
                ST_SHIFT: begin
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    sh_hi   <= sh_hi << 1;
                    sh_lo   <= sh_lo << 1;
                    bcd_hi  <= dabble(bcd_hi, sh_hi[BIN_W-1]);
                    bcd_lo  <= dabble(bcd_lo, sh_lo[BIN_W-1]);
                end
                ST_COMMIT: begin
                    disp   <= disp_new;
                    ovf_hi <= ovf_hi_c;
                    ovf_lo <= ovf_lo_c;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        idx_nxt = idx;
        if (&dwell_cnt)
            idx_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end

    // an and seg are both built from next-cycle index and display so they switch together.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            dwell_cnt <= '0;
            idx       <= '0;
            an        <= ~NUM_DIGITS'(1);
            seg       <= 7'h7F;
        end else begin
            dwell_cnt <= dwell_cnt + DWELL_LOG2'(1);
            idx       <= idx_nxt;
            an        <= ~(NUM_DIGITS'(1) << idx_nxt);
            seg       <= decode(disp_nxt[4*idx_nxt +: 4]);
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_ssd_num_scanner.sv
// Bench for ssd_num_scanner: directed vector table, hand-written timing
// sequences and randomized frames checked against an arithmetic reference.
module tb_ssd_num_scanner;
    logic        board_clk = 1'b0;
    logic        Reset     = 1'b1;
    logic [1:0]  mode      = 2'd0;
    logic [7:0]  val_hi    = 8'd0;
    logic [7:0]  val_lo    = 8'd0;
    logic        blank_lz  = 1'b0;
    logic [31:0] glyphs_a  = 32'h0;
    logic [15:0] glyphs_b  = 16'h0;
    logic [23:0] glyphs_c  = 24'h0;

    logic [7:0] an_a;  logic [6:0] seg_a; logic dp_a, cd_a, oh_a, ol_a;
    logic [3:0] an_b;  logic [6:0] seg_b; logic dp_b, cd_b, oh_b, ol_b;
    logic [5:0] an_c;  logic [6:0] seg_c; logic dp_c, cd_c, oh_c, ol_c;

    int checks = 0;
    int failures = 0;

    logic [6:0] segtab [16] = '{7'h7F, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h01, 7'h47, 7'h0C, 7'h48, 7'h08, 7'h18};
    logic [6:0] got [16];

    ssd_num_scanner #(.NUM_DIGITS(8), .DWELL_LOG2(1), .BIN_W(8)) dut_a (
        .board_clk(board_clk), .Reset(Reset), .mode(mode), .glyphs(glyphs_a),
        .val_hi(val_hi), .val_lo(val_lo), .blank_lz(blank_lz), .an(an_a), .seg(seg_a),
        .dp(dp_a), .conv_done(cd_a), .ovf_hi(oh_a), .ovf_lo(ol_a));

    ssd_num_scanner #(.NUM_DIGITS(4), .DWELL_LOG2(1), .BIN_W(8)) dut_b (
        .board_clk(board_clk), .Reset(Reset), .mode(mode), .glyphs(glyphs_b),
        .val_hi(val_hi), .val_lo(val_lo), .blank_lz(blank_lz), .an(an_b), .seg(seg_b),
        .dp(dp_b), .conv_done(cd_b), .ovf_hi(oh_b), .ovf_lo(ol_b));

    ssd_num_scanner #(.NUM_DIGITS(6), .DWELL_LOG2(2), .BIN_W(8)) dut_c (
        .board_clk(board_clk), .Reset(Reset), .mode(mode), .glyphs(glyphs_c),
        .val_hi(val_hi), .val_lo(val_lo), .blank_lz(blank_lz), .an(an_c), .seg(seg_c),
        .dp(dp_c), .conv_done(cd_c), .ovf_hi(oh_c), .ovf_lo(ol_c));

    always #5 board_clk = ~board_clk;

    typedef struct {
        logic [1:0]  md;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        blz;
        logic [31:0] gl;
        logic [31:0] exp_codes;
    } vec_t;

    task automatic tick();
        @(posedge board_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_conv(input bit which);
        int n;
        n = 0;
        tick();
        while ((which ? cd_b : cd_a) !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) begin
            checks++;
            failures++;
            $display("FAIL conv_done_timeout actual=none expected=pulse");
        end
    endtask

    task automatic settle();
        wait_conv(1'b0);
        wait_conv(1'b0);
    endtask

    // Watch one full scan (16 cycles) and record seg per lit digit.
    task automatic capture(input bit which);
        logic [15:0] an_sel;
        int zeros, pos;
        bit  bad;
        bad = 1'b0;
        for (int i = 0; i < 16; i++) got[i] = 'x;
        for (int t = 0; t < 16; t++) begin
            an_sel = which ? {12'hFFF, an_b} : {8'hFF, an_a};
            zeros = 0;
            pos = 0;
            for (int i = 0; i < 16; i++) if (an_sel[i] == 1'b0) begin zeros++; pos = i; end
            if (zeros != 1) bad = 1'b1;
            else got[pos] = which ? seg_b : seg_a;
            tick();
        end
        chk($sformatf("an_onehot_low_dut%0d", which), {31'd0, bad}, 32'd0);
    endtask

    function automatic int pow10(input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] model_seg(input int nd, input int d, input logic [1:0] md,
                                             input int hi, input int lo, input logic blz,
                                             input logic [31:0] gl);
        int fd, v, j;
        logic [3:0] code;
        fd = nd / 2;
        if (md == 2'd1 || (md == 2'd2 && d < fd)) begin
            v = (d >= fd) ? hi : lo;
            j = d % fd;
            if (v > pow10(fd) - 1) code = 4'hF;
            else if (blz && j > 0 && v < pow10(j)) code = 4'h0;
            else begin
                code = 4'((v / pow10(j)) % 10);
                if (code == 4'h0) code = 4'hA;
            end
        end else begin
            code = gl[4*d +: 4];
        end
        return segtab[code];
    endfunction

    task automatic window_b(input string tag, input logic [27:0] exp);
        int pos;
        for (int n = 0; n < 10; n++) begin
            pos = 0;
            for (int i = 0; i < 4; i++) if (an_b[i] == 1'b0) pos = i;
            chk($sformatf("%s_cyc%0d_dig%0d", tag, n, pos), {25'd0, seg_b}, {25'd0, exp[7*pos +: 7]});
            tick();
        end
        chk($sformatf("%s_period", tag), {31'd0, cd_b}, 32'd1);
    endtask

    vec_t vecs [8];

    initial begin
        int first_cd, second_cd;
        logic [31:0] codes;
        logic [6:0]  exp_s;
        logic [27:0] w12, w34;

        vecs[0] = '{2'd1, 8'd200, 8'd7,   1'b1, 32'h0,         32'h02AA_0007};
        vecs[1] = '{2'd1, 8'd0,   8'd0,   1'b1, 32'h0,         32'h000A_000A};
        vecs[2] = '{2'd1, 8'd0,   8'd0,   1'b0, 32'h0,         32'hAAAA_AAAA};
        vecs[3] = '{2'd0, 8'd55,  8'd66,  1'b1, 32'h1234_5678, 32'h1234_5678};
        vecs[4] = '{2'd3, 8'd1,   8'd2,   1'b0, 32'hEDCB_A90F, 32'hEDCB_A90F};
        vecs[5] = '{2'd2, 8'd77,  8'd34,  1'b1, 32'hE1E1_5555, 32'hE1E1_0034};
        vecs[6] = '{2'd1, 8'd255, 8'd100, 1'b0, 32'h0,         32'hA255_A1AA};
        vecs[7] = '{2'd1, 8'd10,  8'd9,   1'b1, 32'h0,         32'h001A_0009};

        // Reset values
        repeat (3) tick();
        chk("rst_an_a",  {24'd0, an_a}, 32'hFE);
        chk("rst_an_b",  {28'd0, an_b}, 32'hE);
        chk("rst_an_c",  {26'd0, an_c}, 32'h3E);
        chk("rst_seg_a", {25'd0, seg_a}, 32'h7F);
        chk("rst_dp_a",  {31'd0, dp_a}, 32'd1);
        chk("rst_cd_a",  {31'd0, cd_a}, 32'd0);
        chk("rst_ovf_a", {30'd0, oh_a, ol_a}, 32'd0);

        // Release: scan stepping on dut_c and conversion cadence on dut_a
        Reset = 1'b0;
        first_cd = -1;
        second_cd = -1;
        chk("scan_c_k0", {26'd0, an_c}, {26'd0, ~(6'b1 << 0)});
        for (int k = 1; k <= 23; k++) begin
            tick();
            chk($sformatf("scan_c_k%0d", k), {26'd0, an_c}, {26'd0, ~(6'b1 << ((k / 4) % 6))});
            if (cd_a === 1'b1) begin
                if (first_cd < 0) first_cd = k;
                else if (second_cd < 0) second_cd = k;
            end
        end
        chk("first_conv_done_cycle", first_cd, 32'd10);
        chk("second_conv_done_cycle", second_cd, 32'd20);

        // Reset mid-SHIFT and mid-scan (dut_c currently on digit 5)
        chk("pre_rst_an_c", {26'd0, an_c}, 32'h1F);
        Reset = 1'b1;
        #1;
        chk("midrst_an_a",  {24'd0, an_a}, 32'hFE);
        chk("midrst_seg_a", {25'd0, seg_a}, 32'h7F);
        chk("midrst_cd_a",  {31'd0, cd_a}, 32'd0);
        chk("midrst_an_c",  {26'd0, an_c}, 32'h3E);
        tick();
        tick();
        Reset = 1'b0;

        // Directed vector table on the 8-digit instance
        for (int v = 0; v < 8; v++) begin
            mode = vecs[v].md; val_hi = vecs[v].hi; val_lo = vecs[v].lo;
            blank_lz = vecs[v].blz; glyphs_a = vecs[v].gl;
            settle();
            capture(1'b0);
            codes = vecs[v].exp_codes;
            for (int d = 0; d < 8; d++)
                chk($sformatf("vec%0d_dig%0d", v, d), {25'd0, got[d]}, {25'd0, segtab[codes[4*d +: 4]]});
            chk($sformatf("vec%0d_ovf", v), {30'd0, oh_a, ol_a}, 32'd0);
        end

        // Overflow and its boundary on the 4-digit instance
        mode = 2'd1; val_hi = 8'd150; val_lo = 8'd99; blank_lz = 1'b0;
        settle();
        capture(1'b1);
        chk("ovf1_dig3", {25'd0, got[3]}, 32'h18);
        chk("ovf1_dig2", {25'd0, got[2]}, 32'h18);
        chk("ovf1_dig1", {25'd0, got[1]}, 32'h04);
        chk("ovf1_dig0", {25'd0, got[0]}, 32'h04);
        chk("ovf1_flags", {30'd0, oh_b, ol_b}, 32'b10);
        val_hi = 8'd99; val_lo = 8'd100; blank_lz = 1'b1;
        settle();
        capture(1'b1);
        chk("ovf2_dig3", {25'd0, got[3]}, 32'h04);
        chk("ovf2_dig0", {25'd0, got[0]}, 32'h18);
        chk("ovf2_flags", {30'd0, oh_b, ol_b}, 32'b01);

        // Frame atomicity: val_lo 12 -> 34 two cycles after a commit
        mode = 2'd2; glyphs_b = 16'hE100; val_lo = 8'd12; blank_lz = 1'b1;
        settle();
        w12 = {segtab[14], segtab[1], segtab[1], segtab[2]};
        w34 = {segtab[14], segtab[1], segtab[3], segtab[4]};
        wait_conv(1'b1);
        tick();
        tick();
        val_lo = 8'd34;
        wait_conv(1'b1);
        window_b("atom_old", w12);
        window_b("atom_new", w34);

        // Randomized frames against the arithmetic model
        for (int r = 0; r < 20; r++) begin
            mode = 2'($urandom_range(0, 3));
            val_hi = 8'($urandom_range(0, 255));
            val_lo = (r % 4 == 0) ? 8'($urandom_range(95, 105)) : 8'($urandom_range(0, 255));
            blank_lz = 1'($urandom_range(0, 1));
            glyphs_a = $urandom;
            glyphs_b = 16'($urandom);
            settle();
            capture(1'b0);
            for (int d = 0; d < 8; d++) begin
                exp_s = model_seg(8, d, mode, val_hi, val_lo, blank_lz, glyphs_a);
                chk($sformatf("rnd%0d_a_dig%0d", r, d), {25'd0, got[d]}, {25'd0, exp_s});
            end
            capture(1'b1);
            for (int d = 0; d < 4; d++) begin
                exp_s = model_seg(4, d, mode, val_hi, val_lo, blank_lz, {16'd0, glyphs_b});
                chk($sformatf("rnd%0d_b_dig%0d", r, d), {25'd0, got[d]}, {25'd0, exp_s});
            end
            if (mode == 2'd1)
                chk($sformatf("rnd%0d_b_ovf_hi", r), {31'd0, oh_b}, {31'd0, (val_hi > 8'd99)});
            if (mode == 2'd1 || mode == 2'd2)
                chk($sformatf("rnd%0d_b_ovf_lo", r), {31'd0, ol_b}, {31'd0, (val_lo > 8'd99)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
